error_message_sequencer: RTL and testbench

- Sits directly downstream of the error handler in coffee_machine_top.
- Consumes the raw err_* / warn_* flags and glitch-filters each one.
- Latches the system fault until an operator acknowledges it.
- Rotates the active conditions into a single message code for the LCD/HEX drivers, and produces a filtered critical_error for the brew FSM.

---
 rtl/error_message_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_error_message_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/error_message_sequencer.sv
// Glitch-filters error/warning flags, latches the system fault until acknowledged,
// and rotates the active conditions into one message code for the display drivers.
module error_message_sequencer #(
    parameter int FILTER_CYCLES = 16,
    parameter int DWELL_CYCLES  = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] err_flags,
    input  logic [5:0] warn_flags,
    input  logic       fault_ack,
    output logic [3:0] msg_code,
    output logic       msg_is_error,
    output logic       msg_new,
    output logic       critical_error,
    output logic [3:0] err_count,
    output logic [3:0] warn_count,
    output logic       alarm_led
);
    localparam int FC_W = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES);
    localparam int DW_W = $clog2(DWELL_CYCLES);
    localparam logic [FC_W-1:0] FILT_LAST  = FC_W'(FILTER_CYCLES - 1);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
    localparam logic [DW_W-1:0] HALF_LAST  = DW_W'(DWELL_CYCLES / 2 - 1);

    typedef enum logic {IDLE, SHOW} state_t;

    function automatic logic [3:0] lowest_set(input logic [11:0] v);
        logic [3:0] res;
        res = 4'd0;
        for (int k = 11; k >= 0; k--) begin
            if (v[k]) res = 4'(k);
        end
        return res;
    endfunction

    // First active slot strictly above cur, wrapping; returns cur if it is the only one.
    function automatic logic [3:0] next_above(input logic [11:0] v, input logic [3:0] cur);
        logic [3:0] res;
        logic       found;
        logic [4:0] s;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k < 12; k++) begin
            s = {1'b0, cur} + 5'(k);
            if (s >= 5'd12) s = s - 5'd12;
            if (!found && v[s[3:0]]) begin
                res   = s[3:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] popcount6(input logic [5:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int k = 0; k < 6; k++) n = n + {3'd0, v[k]};
        return n;
    endfunction

    logic [11:0]           raw;
    logic [11:0]           filt_q, filt_d;
    logic [11:0][FC_W-1:0] fcnt_q, fcnt_d;
    logic                  latch_q, latch_d;
    logic [11:0]           act;
    logic [5:0]            a_prev_q;
    logic [5:0]            rise;
    state_t                state_q, state_d;
    logic [3:0]            slot_q, slot_d;
    logic [DW_W-1:0]       dwell_q, dwell_d;
    logic [3:0]            code_d;
    logic                  msg_new_q;
    logic                  crit_q;
    logic [3:0]            err_cnt_q, warn_cnt_q;
    logic [DW_W-1:0]       half_q, half_d;
    logic                  led_q, led_d;

    assign raw = {warn_flags, err_flags};

    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        for (int i = 0; i < 12; i++) begin
            if (raw[i] == filt_q[i]) begin
                fcnt_d[i] = '0;
            end else if (fcnt_q[i] == FILT_LAST) begin
                filt_d[i] = raw[i];
                fcnt_d[i] = '0;
            end else begin
                fcnt_d[i] = fcnt_q[i] + 1'b1;
            end
        end
    end

    // Latch sets on the same edge the filtered bit rises, so a coincident ack loses.
    assign latch_d = filt_d[5] | (latch_q & ~(fault_ack & ~filt_q[5]));
    assign act     = {filt_q[11:6], latch_q, filt_q[4:0]};
    assign rise    = act[5:0] & ~a_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            slot_q  <= 4'd0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            dwell_q <= dwell_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        dwell_d = '0;
        case (state_q)
            IDLE: begin
                if (act != 12'd0) begin
                    state_d = SHOW;
                    slot_d  = lowest_set(act);
                end
            end
            SHOW: begin
                if (act == 12'd0) begin
                    state_d = IDLE;
                end else if (!act[slot_q]) begin
                    slot_d = next_above(act, slot_q);
                end else if (slot_q >= 4'd6 && rise != 6'd0) begin
                    slot_d = lowest_set({6'd0, rise});
                end else if (dwell_q == DWELL_LAST) begin
                    slot_d = next_above(act, slot_q);
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        msg_code     = (state_q == SHOW) ? slot_q + 4'd1 : 4'd0;
        code_d       = (state_d == SHOW) ? slot_d + 4'd1 : 4'd0;
        msg_is_error = (msg_code != 4'd0) && (msg_code <= 4'd6);
    end

    always_comb begin
        half_d = '0;
        led_d  = 1'b0;
        if (crit_q) begin
            if (half_q == HALF_LAST) begin
                led_d = ~led_q;
            end else begin
                half_d = half_q + 1'b1;
                led_d  = led_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q     <= '0;
            fcnt_q     <= '0;
            latch_q    <= 1'b0;
            a_prev_q   <= '0;
            msg_new_q  <= 1'b0;
            crit_q     <= 1'b0;
            err_cnt_q  <= 4'd0;
            warn_cnt_q <= 4'd0;
            half_q     <= '0;
            led_q      <= 1'b0;
        end else begin
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            latch_q    <= latch_d;
            a_prev_q   <= act[5:0];
            msg_new_q  <= (code_d != msg_code);
            crit_q     <= |act[5:0];
            err_cnt_q  <= popcount6(act[5:0]);
            warn_cnt_q <= popcount6(act[11:6]);
            half_q     <= half_d;
            led_q      <= led_d;
        end
    end

    assign msg_new        = msg_new_q;
    assign critical_error = crit_q;
    assign err_count      = err_cnt_q;
    assign warn_count     = warn_cnt_q;
    assign alarm_led      = led_q;
endmodule

// File: tb/tb_error_message_sequencer.sv
// Bench for error_message_sequencer: directed scenarios plus random flag traffic,
// every cycle compared against a behavioural model of the sequencer.
module tb_error_message_sequencer;
    localparam int FC   = 4;
    localparam int DC   = 8;
    localparam int HALF = DC / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] err_flags = 6'd0;
    logic [5:0] warn_flags = 6'd0;
    logic       fault_ack = 1'b0;
    logic [3:0] msg_code;
    logic       msg_is_error;
    logic       msg_new;
    logic       critical_error;
    logic [3:0] err_count;
    logic [3:0] warn_count;
    logic       alarm_led;

    error_message_sequencer #(.FILTER_CYCLES(FC), .DWELL_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .err_flags(err_flags), .warn_flags(warn_flags),
        .fault_ack(fault_ack), .msg_code(msg_code), .msg_is_error(msg_is_error),
        .msg_new(msg_new), .critical_error(critical_error), .err_count(err_count),
        .warn_count(warn_count), .alarm_led(alarm_led)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state
    bit [11:0] m_filt;
    int        m_run[12];
    bit        m_latch;
    bit        m_show;
    int        m_slot;
    int        m_shown_for;
    bit [5:0]  m_prev_err;
    bit        m_crit;
    int        m_ec, m_wc;
    int        m_crit_age;
    bit        m_led;
    int        m_code;
    bit        m_new;

    function automatic int lowest(input bit [11:0] v);
        for (int i = 0; i < 12; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int next_active(input bit [11:0] v, input int s);
        for (int k = 1; k < 12; k++) if (v[(s + k) % 12]) return (s + k) % 12;
        return s;
    endfunction

    task automatic model_clear();
        m_filt = '0;
        foreach (m_run[i]) m_run[i] = 0;
        m_latch = 0; m_show = 0; m_slot = 0; m_shown_for = 0; m_prev_err = '0;
        m_crit = 0; m_ec = 0; m_wc = 0; m_crit_age = 0; m_led = 0; m_code = 0; m_new = 0;
    endtask

    task automatic model_edge(input bit r, input bit [5:0] e, input bit [5:0] w, input bit ack);
        bit [11:0] a;
        bit [11:0] rawv;
        bit [5:0]  newly;
        int        old_code;
        bit        old_sys;
        if (r) begin
            model_clear();
            return;
        end
        a        = {m_filt[11:6], m_latch, m_filt[4:0]};
        newly    = a[5:0] & ~m_prev_err;
        old_code = m_code;
        if (!m_show) begin
            if (a != 0) begin m_show = 1; m_slot = lowest(a); m_shown_for = 0; end
        end else if (a == 0) begin
            m_show = 0; m_shown_for = 0;
        end else if (!a[m_slot]) begin
            m_slot = next_active(a, m_slot); m_shown_for = 0;
        end else if (m_slot >= 6 && newly != 0) begin
            m_slot = lowest({6'd0, newly}); m_shown_for = 0;
        end else if (m_shown_for == DC - 1) begin
            m_slot = next_active(a, m_slot); m_shown_for = 0;
        end else begin
            m_shown_for++;
        end
        m_code     = m_show ? m_slot + 1 : 0;
        m_new      = (m_code != old_code);
        m_prev_err = a[5:0];
        if (m_crit) begin
            m_crit_age++;
            m_led = ((m_crit_age / HALF) % 2) == 1;
        end else begin
            m_crit_age = 0;
            m_led = 0;
        end
        m_crit = (a[5:0] != 0);
        m_ec   = $countones(a[5:0]);
        m_wc   = $countones(a[11:6]);
        old_sys = m_filt[5];
        rawv    = {w, e};
        for (int i = 0; i < 12; i++) begin
            if (rawv[i] != m_filt[i]) begin
                m_run[i]++;
                if (m_run[i] == FC) begin m_filt[i] = rawv[i]; m_run[i] = 0; end
            end else begin
                m_run[i] = 0;
            end
        end
        m_latch = m_filt[5] | (m_latch & !(ack & !old_sys));
    endtask

    task automatic step();
        bit       r;
        bit [5:0] e;
        bit [5:0] w;
        bit       ack;
        r = rst; e = err_flags; w = warn_flags; ack = fault_ack;
        @(posedge clk);
        model_edge(r, e, w, ack);
        #1;
        check("msg_code", int'(msg_code), m_code);
        check("msg_is_error", int'(msg_is_error), int'(m_code >= 1 && m_code <= 6));
        check("msg_new", int'(msg_new), int'(m_new));
        check("critical_error", int'(critical_error), int'(m_crit));
        check("err_count", int'(err_count), m_ec);
        check("warn_count", int'(warn_count), m_wc);
        check("alarm_led", int'(alarm_led), int'(m_led));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int idx;

    initial begin
        model_clear();
        rst = 1'b1;
        run(2);
        check("reset_code", int'(msg_code), 0);
        check("reset_crit", int'(critical_error), 0);
        rst = 1'b0;
        run(2);

        // Short glitch is rejected
        err_flags = 6'b000001;
        run(3);
        err_flags = 6'd0;
        run(10);
        check("glitch_crit", int'(critical_error), 0);
        check("glitch_code", int'(msg_code), 0);

        // Single error held across several dwell periods
        err_flags = 6'b000010;
        run(30);
        check("single_code", int'(msg_code), 2);
        check("single_is_err", int'(msg_is_error), 1);
        check("single_count", int'(err_count), 1);
        err_flags = 6'd0;
        run(10);

        // Rotation between an error and a warning
        err_flags  = 6'b000001;
        warn_flags = 6'b001000;
        run(40);
        err_flags  = 6'd0;
        warn_flags = 6'd0;
        run(10);

        // Error preempts a warning without waiting for the dwell
        warn_flags = 6'b000010;
        run(10);
        check("preempt_warn", int'(msg_code), 8);
        err_flags = 6'b010000;
        run(FC + 1);
        check("preempt_err", int'(msg_code), 5);
        err_flags  = 6'd0;
        warn_flags = 6'd0;
        run(12);

        // System fault latch held until acknowledged
        err_flags = 6'b100000;
        run(6);
        err_flags = 6'd0;
        run(15);
        check("latch_crit", int'(critical_error), 1);
        check("latch_code", int'(msg_code), 6);
        fault_ack = 1'b1;
        step();
        fault_ack = 1'b0;
        run(3);
        check("ack_crit", int'(critical_error), 0);
        check("ack_code", int'(msg_code), 0);
        check("ack_led", int'(alarm_led), 0);

        // Ack coincident with a new rise: set wins
        err_flags = 6'b100000;
        run(FC - 1);
        fault_ack = 1'b1;
        step();
        fault_ack = 1'b0;
        step();
        err_flags = 6'd0;
        run(12);
        check("coinc_crit", int'(critical_error), 1);
        fault_ack = 1'b1;
        step();
        fault_ack = 1'b0;
        run(4);

        // Reset in the middle of showing a warning
        warn_flags = 6'b001000;
        run(8);
        check("pre_rst_code", int'(msg_code), 10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_code", int'(msg_code), 0);
        check("mid_rst_cnt", int'(warn_count), 0);
        run(FC + 1);
        check("post_rst_code", int'(msg_code), 10);
        warn_flags = 6'd0;
        run(10);

        // Random flag traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                idx = $urandom_range(0, 5);
                err_flags[idx] = ~err_flags[idx];
            end
            if ($urandom_range(0, 5) == 0) begin
                idx = $urandom_range(0, 5);
                warn_flags[idx] = ~warn_flags[idx];
            end
            fault_ack = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        fault_ack = 1'b0;
        run(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
